// File: rtl/macc_seq_if.sv
// Operand-stream and result handshake bundle for the MACC sequencer.
// master = feeder/writeback side, slave = macc_seq side.
interface macc_seq_if #(
  parameter int ACC_W = 24
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [7:0]       in_x;
  logic signed [7:0]       in_y;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic                    out_ovf;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/macc_seq.sv
// macc_seq: sequencing controller for the shared 8x8 signed Booth multiplier.
// Registers each accepted operand pair into the multiplier, accumulates the
// sign-extended 15-bit product one cycle later, and returns the dot product
// through a valid/ready handshake.
// Optional feature macro: MACC_SAT_EN (saturating accumulate + sticky out_ovf);
// when undefined the accumulator wraps and out_ovf is tied low.
module macc_seq #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  output logic signed [7:0]       mul_x,
  output logic signed [7:0]       mul_y,
  input  logic signed [14:0]      mul_p,
  macc_seq_if.slave               io
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt;
  logic                    hs_p0;
  logic                    vld_p1;
  logic                    start_ok;
  logic                    last_p0;
  logic signed [ACC_W-1:0] acc;

`ifdef MACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic ovf;

  // One extra guard bit: overflow shows as the guard and sign bits disagreeing.
  function automatic logic signed [ACC_W:0] wide_sum(
    input logic signed [ACC_W-1:0] a,
    input logic signed [14:0]      p
  );
    return {a[ACC_W-1], a} + {{(ACC_W-14){p[14]}}, p};
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] s);
    if (sat_hit(s)) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] wrap_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [14:0]      p
  );
    return a + {{(ACC_W-15){p[14]}}, p};
  endfunction
`endif

  assign start_ok = start && (state == IDLE);
  assign hs_p0    = io.in_valid && (state == RUN);
  assign last_p0  = (cnt + LEN_W'(1)) == len_q;

  // State register; reset aborts any dot product in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from the state.
  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        io.in_ready = 1'b1;
        if (hs_p0 && last_p0) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Term counter, latched length and product-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= hs_p0;
      if (start_ok) begin
        len_q <= len;
        cnt   <= '0;
      end else if (hs_p0) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  // ---- stage p0 -> p1: operand register feeding the multiplier ----
  // Operands hold when no pair is accepted so the product input stays quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_x <= '0;
      mul_y <= '0;
    end else if (hs_p0) begin
      mul_x <= io.in_x;
      mul_y <= io.in_y;
    end
  end

  // ---- stage p1 -> acc: accumulate the product one cycle after acceptance ----
`ifdef MACC_SAT_EN
  // Saturating accumulate with a sticky clamp flag, both cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_ok) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (vld_p1) begin
      acc <= sat_clip(wide_sum(acc, mul_p));
      ovf <= ovf | sat_hit(wide_sum(acc, mul_p));
    end
  end

  assign io.out_ovf = ovf;
`else
  // Wrap-around accumulate, cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           acc <= '0;
    else if (start_ok) acc <= '0;
    else if (vld_p1)   acc <= wrap_add(acc, mul_p);
  end

  assign io.out_ovf = 1'b0;
`endif

  assign io.out_acc = acc;

endmodule

// File: tb/tb_macc_seq.sv
// Bench for macc_seq: a 24-bit and a 16-bit instance run in lockstep on the
// same stimulus; directed table entries plus randomized dot products checked
// against an arithmetic reference model.
module tb_macc_seq;

`ifdef MACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int     n;
    int     xs[16];
    int     ys[16];
    bit     gaps;
    int     hold;
    longint e24;
    longint e16;
    bit     o16;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        len;
  logic              busy, busy16;
  logic signed [7:0] mul_x, mul_y, mul_x16, mul_y16;
  logic signed [14:0] mul_p, mul_p16;

  int n_chk = 0;
  int n_err = 0;

  macc_seq_if #(.ACC_W(24)) bus ();
  macc_seq_if #(.ACC_W(16)) bus16 ();

  assign bus16.in_valid  = bus.in_valid;
  assign bus16.in_x      = bus.in_x;
  assign bus16.in_y      = bus.in_y;
  assign bus16.out_ready = bus.out_ready;

  // 15-bit truncating multiplier, as the shared Booth unit behaves.
  assign mul_p   = $signed({{7{mul_x[7]}}, mul_x}) * $signed({{7{mul_y[7]}}, mul_y});
  assign mul_p16 = $signed({{7{mul_x16[7]}}, mul_x16}) * $signed({{7{mul_y16[7]}}, mul_y16});

  macc_seq #(.ACC_W(24), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p), .io(bus)
  );

  macc_seq #(.ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy16),
    .mul_x(mul_x16), .mul_y(mul_y16), .mul_p(mul_p16), .io(bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Dot product from plain integer arithmetic: the multiplier cannot show
  // +16384, per-step clamping when saturating, final modulo 2^w otherwise.
  function automatic void ref_dot(input int n, input int xs[16], input int ys[16],
                                  input int w, input bit sat,
                                  output longint res, output bit ovf);
    longint s = 0;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    longint p;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(xs[i]) * longint'(ys[i]);
      if (p == 16384) p = -16384;
      s = s + p;
      if (sat) begin
        if (s > hi) begin s = hi; ovf = 1'b1; end
        if (s < lo) begin s = lo; ovf = 1'b1; end
      end
    end
    if (!sat) begin
      s = s & ((longint'(1) << w) - 1);
      if (s > hi) s = s - (longint'(1) << w);
    end
    res = s;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int  k = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  hs;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(v.n);
    @(negedge clk);
    start = 1'b0;
    if (v.n == 0) begin
      chk({tag, " len0_valid"}, bus.out_valid, 1);
      chk({tag, " len0_ready"}, bus.in_ready, 0);
    end else begin
      chk({tag, " run_ready"}, bus.in_ready, 1);
      while (k < v.n && cyc < 4 * v.n + 8) begin
        bus.in_valid = v.gaps ? tog : 1'b1;
        tog = !tog;
        if (bus.in_valid) begin
          bus.in_x = 8'(v.xs[k]);
          bus.in_y = 8'(v.ys[k]);
        end else begin
          bus.in_x = 8'($urandom);
          bus.in_y = 8'($urandom);
        end
        hs = bus.in_valid && bus.in_ready;
        @(negedge clk);
        cyc++;
        if (hs) begin
          chk({tag, " mul_x"}, mul_x, v.xs[k]);
          chk({tag, " mul_y"}, mul_y, v.ys[k]);
          k++;
        end
      end
      bus.in_valid = 1'b0;
      chk({tag, " accepted"}, k, v.n);
      chk({tag, " drain_ready"}, bus.in_ready, 0);
      chk({tag, " drain_valid"}, bus.out_valid, 0);
      @(negedge clk);
      chk({tag, " latency_valid"}, bus.out_valid, 1);
    end
    for (int h = 0; h < v.hold; h++) begin
      chk({tag, " hold_valid"}, bus.out_valid, 1);
      chk({tag, " hold_busy"}, busy, 1);
      chk({tag, " hold_acc"}, bus.out_acc, v.e24);
      start = 1'b1;
      len   = 8'd1;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " acc24"}, bus.out_acc, v.e24);
    chk({tag, " ovf24"}, bus.out_ovf, 0);
    chk({tag, " acc16"}, bus16.out_acc, v.e16);
    chk({tag, " ovf16"}, bus16.out_ovf, v.o16);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " post_valid"}, bus.out_valid, 0);
    chk({tag, " post_busy"}, busy, 0);
    chk({tag, " post_acc"}, bus.out_acc, v.e24);
  endtask

  vec_t tv[7];
  vec_t rv;
  bit   dummy;

  initial begin
    tv[0] = '{n:1, xs:'{0:-2, default:0}, ys:'{0:9, default:0},
              gaps:0, hold:0, e24:-18, e16:-18, o16:0};
    tv[1] = '{n:3, xs:'{0:3, 1:-5, 2:7, default:0}, ys:'{0:4, 1:6, 2:-8, default:0},
              gaps:0, hold:0, e24:-74, e16:-74, o16:0};
    tv[2] = '{n:0, xs:'{default:0}, ys:'{default:0},
              gaps:0, hold:0, e24:0, e16:0, o16:0};
    tv[3] = '{n:4, xs:'{0:127, 1:127, 2:127, 3:127, default:0},
              ys:'{0:127, 1:127, 2:127, 3:127, default:0},
              gaps:1, hold:0, e24:64516, e16:(SAT ? 32767 : -1020), o16:SAT};
    tv[4] = '{n:2, xs:'{0:-128, 1:-128, default:0}, ys:'{0:127, 1:127, default:0},
              gaps:0, hold:5, e24:-32512, e16:-32512, o16:0};
    tv[5] = '{n:3, xs:'{0:127, 1:127, 2:127, default:0}, ys:'{0:127, 1:127, 2:127, default:0},
              gaps:0, hold:0, e24:48387, e16:(SAT ? 32767 : -17149), o16:SAT};
    tv[6] = '{n:5, xs:'{0:127, 1:127, 2:127, 3:-128, 4:-128, default:0},
              ys:'{0:127, 1:127, 2:127, 3:127, 4:127, default:0},
              gaps:0, hold:1, e24:15875, e16:(SAT ? 255 : 15875), o16:SAT};

    rst = 1'b1;
    start = 1'b0;
    len = '0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_acc", bus.out_acc, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_mul_x", mul_x, 0);
    @(negedge clk);
    rst = 1'b0;

    // Abort mid-RUN after 2 of 5 pairs.
    @(negedge clk);
    start = 1'b1;
    len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_x = 8'sd10;
    bus.in_y = 8'sd10;
    @(negedge clk);
    bus.in_x = 8'sd20;
    bus.in_y = 8'sd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_acc", bus.out_acc, 0);
    chk("abort_mul_x", mul_x, 0);
    chk("abort_mul_y", mul_y, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(tv[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 25; r++) begin
      rv.n = $urandom_range(1, 10);
      for (int j = 0; j < 16; j++) begin
        rv.xs[j] = int'($urandom_range(0, 255)) - 128;
        rv.ys[j] = int'($urandom_range(0, 255)) - 128;
        if (rv.xs[j] == -128 && rv.ys[j] == -128) rv.ys[j] = -127;
      end
      rv.gaps = 1'($urandom_range(0, 1));
      rv.hold = $urandom_range(0, 2);
      ref_dot(rv.n, rv.xs, rv.ys, 24, SAT, rv.e24, dummy);
      ref_dot(rv.n, rv.xs, rv.ys, 16, SAT, rv.e16, rv.o16);
      run(rv, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/macc_seq.md
Name: macc_seq

Overview:
Sequencing controller for the shared 8x8 signed radix-4 Booth multiplier (combinational, 15-bit product) in the MACC unit. It accepts a stream of operand pairs for one CNN dot product (kernel window x weights) and registers each pair into the multiplier. It accumulates the sign-extended products and returns a single accumulated result through a valid/ready handshake. It sits between the convolution window feeder (upstream) and the activation/writeback stage (downstream).

Parameters:
ACC_W, 24, accumulator and result width in bits (>= 16).
LEN_W, 8, width of the term-count field; one dot product has at most 2^LEN_W-1 terms.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a dot product; sampled only in IDLE
len  input  LEN_W  number of operand pairs; latched on start
busy  output  1  high in every state except IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept a pair
in_x  input  8  signed activation
in_y  input  8  signed weight
mul_x  output  8  registered operand to multiplier x
mul_y  output  8  registered operand to multiplier y
mul_p  input  15  multiplier product, combinational from mul_x/mul_y
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  signed accumulated result
out_ovf  output  1  sticky saturation flag (see Optional Feature)

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, in_ready=0, mul_x=0, mul_y=0, out_valid=0, out_acc=0, out_ovf=0, term counter=0, p_vld=0.
- Reset asserted mid-operation aborts the dot product immediately. No partial result is emitted.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0: latch len, clear acc and out_ovf, go to RUN.
  - start=1 and len==0: clear acc, go straight to DONE. Result is 0.
  - in_ready=0.
- RUN:
  - in_ready=1.
  - Handshake on in_valid & in_ready: mul_x<=in_x, mul_y<=in_y, p_vld<=1, counter++.
  - No handshake: p_vld<=0 and mul_x/mul_y hold.
  - When the handshake accepts the len-th pair, go to DRAIN. in_ready is 0 from the next cycle.
- Accumulate, in any state: when p_vld=1, acc <= acc + sign_extend(mul_p[14:0], ACC_W). Exactly one accumulate per accepted pair, one cycle after acceptance.
- DRAIN: lasts one cycle, during which the final product is accumulated. Then go to DONE.
- DONE:
  - out_valid=1, out_acc=acc. Both hold stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE. out_valid falls the next cycle.
- Latency: last input handshake at edge t gives out_valid=1 after edge t+1.
- Throughput: one pair per cycle; no bubbles required.
- start is ignored outside IDLE. in_valid is ignored when in_ready=0.
- out_acc keeps its value in IDLE after a result is consumed. It is cleared only on a new start.
- Product range: the multiplier's 15-bit product cannot represent (-128)*(-128)=+16384; it appears as -16384. The controller does not correct this. Upstream must avoid that pair.

Optional Feature:
MACC_SAT_EN.
- Defined: each accumulate saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)). out_ovf is set on any clamp and stays set until the next start or rst.
- Undefined: two's-complement wrap-around; out_ovf is tied to 0.

Test Plan:
1. len=3; pairs (3,4), (-5,6), (7,-8), back-to-back -> out_valid 2 cycles after the 3rd handshake; out_acc=12-30-56=-74; busy falls after out_ready.
2. len=4; in_valid toggled 1,0,1,0,...; pairs (127,127)x4 -> exactly 4 accumulates; out_acc=64516; in_ready=0 after the 4th accept.
3. start with len=0 -> DONE next cycle; out_valid=1, out_acc=0; no in_ready pulse.
4. Result held with out_ready=0 for 5 cycles -> out_acc stable, out_valid stays 1; start pulses during the hold are ignored (busy stays 1).
5. rst asserted mid-RUN after 2 of 5 pairs -> all outputs at reset values asynchronously; a new start with len=1, pair (-2,9) -> out_acc=-18.
6. ACC_W=16 with MACC_SAT_EN; len=3, pairs (127,127)x3 -> out_acc=32767, out_ovf=1. Without the macro -> out_acc=48387-65536=-17149, out_ovf=0.
